// File: rtl/castle_rights_if.sv
// Move-request / castle-result handshake bundle between move generation and
// the castle_rights_update block. Board is PIECE_WIDTH bits per square, square = row<<3|col.
interface castle_rights_if #(
    parameter int PIECE_WIDTH = 4,
    parameter int BOARD_WIDTH = 64 * PIECE_WIDTH
);
    logic                   move_valid;
    logic                   move_ready;
    logic [BOARD_WIDTH-1:0] board;
    logic [3:0]             castle_mask_in;
    logic [5:0]             from_sq;
    logic [5:0]             to_sq;
    logic                   out_valid;
    logic                   out_ready;
    logic [3:0]             castle_mask;
    logic [3:0]             castle_mask_orig;
    logic                   castle_move;
    logic                   castle_illegal;
    logic [5:0]             rook_from;
    logic [5:0]             rook_to;

    modport master (
        output move_valid, board, castle_mask_in, from_sq, to_sq, out_ready,
        input  move_ready, out_valid, castle_mask, castle_mask_orig,
               castle_move, castle_illegal, rook_from, rook_to
    );

    modport slave (
        input  move_valid, board, castle_mask_in, from_sq, to_sq, out_ready,
        output move_ready, out_valid, castle_mask, castle_mask_orig,
               castle_move, castle_illegal, rook_from, rook_to
    );
endinterface

// File: rtl/castle_rights_update.sv
// Post-move castling-rights update and castling-move decode, one move in flight.
// Optional macro CASTLE_PATH_CHECK_EN adds the empty-path test to castle_illegal.
module castle_rights_update #(
    parameter bit CLEAR_ON_CAPTURE = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    castle_rights_if.slave  mv
);
    localparam int PIECE_WIDTH = 4;
    localparam int BOARD_WIDTH = 64 * PIECE_WIDTH;
    // Piece codes: bit3 = black, low bits 1..6 = pawn,knight,bishop,rook,queen,king.
    // Mask bits: 0 white short, 1 white long, 2 black short, 3 black long.
    localparam logic [3:0] WHITE_ROOK = 4'd4;
    localparam logic [3:0] WHITE_KING = 4'd6;
    localparam logic [3:0] BLACK_ROOK = 4'd12;
    localparam logic [3:0] BLACK_KING = 4'd14;

    typedef enum logic [1:0] {IDLE, DECODE, UPDATE, HOLD} state_t;
    state_t state;

    logic [BOARD_WIDTH-1:0] board_p0;
    logic [3:0]             mask_p0;
    logic [5:0]             from_p0;
    logic [5:0]             to_p0;
    logic [3:0]             from_pc_p1;
    logic [3:0]             rook_pc_p1;
    logic                   path_ok;

    logic [1:0] upd_slot;
    logic       upd_move;
    logic       upd_illegal;
    logic [3:0] upd_mask;

    function automatic logic [3:0] piece_at(input logic [BOARD_WIDTH-1:0] b, input logic [5:0] sq);
        return b[{sq, 2'b00} +: PIECE_WIDTH];
    endfunction

    function automatic logic [1:0] castle_slot(input logic [5:0] sq);
        case (sq)
            6'd2:    return 2'd1;
            6'd62:   return 2'd2;
            6'd58:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [5:0] rook_corner(input logic [1:0] slot);
        case (slot)
            2'd0:    return 6'd7;
            2'd1:    return 6'd0;
            2'd2:    return 6'd63;
            default: return 6'd56;
        endcase
    endfunction

    function automatic logic [5:0] rook_dest(input logic [1:0] slot);
        case (slot)
            2'd0:    return 6'd5;
            2'd1:    return 6'd3;
            2'd2:    return 6'd61;
            default: return 6'd59;
        endcase
    endfunction

    // Rights bit owned by a rook corner; zero for every other square.
    function automatic logic [3:0] corner_bit(input logic [5:0] sq);
        case (sq)
            6'd7:    return 4'b0001;
            6'd0:    return 4'b0010;
            6'd63:   return 4'b0100;
            6'd56:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic is_castle(input logic [3:0] pc, input logic [5:0] fs, input logic [5:0] ts);
        return (pc == WHITE_KING && fs == 6'd4  && (ts == 6'd6  || ts == 6'd2)) ||
               (pc == BLACK_KING && fs == 6'd60 && (ts == 6'd62 || ts == 6'd58));
    endfunction

    function automatic logic [3:0] next_mask(input logic [3:0] orig, input logic [3:0] pc,
                                             input logic [5:0] fs, input logic [5:0] ts);
        logic [3:0] m;
        m = orig & ~corner_bit(fs);
        if (pc == WHITE_KING && fs == 6'd4)  m = m & 4'b1100;
        if (pc == BLACK_KING && fs == 6'd60) m = m & 4'b0011;
        if (CLEAR_ON_CAPTURE)                m = m & ~corner_bit(ts);
        return m;
    endfunction

`ifdef CASTLE_PATH_CHECK_EN
    logic path_clear_p1;

    function automatic logic path_empty(input logic [BOARD_WIDTH-1:0] b, input logic [1:0] slot);
        case (slot)
            2'd0:    return piece_at(b, 6'd5) == 4'd0 && piece_at(b, 6'd6) == 4'd0;
            2'd1:    return piece_at(b, 6'd1) == 4'd0 && piece_at(b, 6'd2) == 4'd0 &&
                            piece_at(b, 6'd3) == 4'd0;
            2'd2:    return piece_at(b, 6'd61) == 4'd0 && piece_at(b, 6'd62) == 4'd0;
            default: return piece_at(b, 6'd57) == 4'd0 && piece_at(b, 6'd58) == 4'd0 &&
                            piece_at(b, 6'd59) == 4'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (state == DECODE) path_clear_p1 <= path_empty(board_p0, castle_slot(to_p0));
    end
    assign path_ok = path_clear_p1;
`else
    assign path_ok = 1'b1;
`endif

    // p0: move captured at acceptance; p1: square contents looked up in DECODE.
    always_ff @(posedge clk) begin
        if (state == IDLE && mv.move_valid && mv.move_ready) begin
            board_p0 <= mv.board;
            mask_p0  <= mv.castle_mask_in;
            from_p0  <= mv.from_sq;
            to_p0    <= mv.to_sq;
        end
        if (state == DECODE) begin
            from_pc_p1 <= piece_at(board_p0, from_p0);
            rook_pc_p1 <= piece_at(board_p0, rook_corner(castle_slot(to_p0)));
        end
    end

    always_comb begin
        upd_slot    = castle_slot(to_p0);
        upd_move    = is_castle(from_pc_p1, from_p0, to_p0);
        upd_mask    = next_mask(mask_p0, from_pc_p1, from_p0, to_p0);
        upd_illegal = upd_move && (!mask_p0[upd_slot] || !path_ok ||
                      rook_pc_p1 != (upd_slot[1] ? BLACK_ROOK : WHITE_ROOK));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            mv.move_ready       <= 1'b0;
            mv.out_valid        <= 1'b0;
            mv.castle_mask      <= 4'd0;
            mv.castle_mask_orig <= 4'd0;
            mv.castle_move      <= 1'b0;
            mv.castle_illegal   <= 1'b0;
            mv.rook_from        <= 6'd0;
            mv.rook_to          <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mv.move_valid && mv.move_ready) begin
                        mv.move_ready <= 1'b0;
                        state         <= DECODE;
                    end else begin
                        mv.move_ready <= 1'b1;
                    end
                end
                DECODE: state <= UPDATE;
                UPDATE: begin
                    mv.castle_mask      <= upd_mask;
                    mv.castle_mask_orig <= mask_p0;
                    mv.castle_move      <= upd_move;
                    mv.castle_illegal   <= upd_illegal;
                    mv.rook_from        <= upd_move ? rook_corner(upd_slot) : 6'd0;
                    mv.rook_to          <= upd_move ? rook_dest(upd_slot) : 6'd0;
                    state               <= HOLD;
                end
                HOLD: begin
                    // Result registers settle one cycle before out_valid rises.
                    if (!mv.out_valid) begin
                        mv.out_valid <= 1'b1;
                    end else if (mv.out_ready) begin
                        mv.out_valid  <= 1'b0;
                        mv.move_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_castle_rights_update.sv
// Directed, table-driven bench for castle_rights_update; a second instance
// built with CLEAR_ON_CAPTURE=0 runs in lockstep for the capture-rule check.
module tb_castle_rights_update;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    castle_rights_if a ();
    castle_rights_if b ();

    assign b.move_valid     = a.move_valid;
    assign b.board          = a.board;
    assign b.castle_mask_in = a.castle_mask_in;
    assign b.from_sq        = a.from_sq;
    assign b.to_sq          = a.to_sq;
    assign b.out_ready      = a.out_ready;

    castle_rights_update #(.CLEAR_ON_CAPTURE(1'b1)) dut  (.clk(clk), .reset(rst_n), .mv(a));
    castle_rights_update #(.CLEAR_ON_CAPTURE(1'b0)) dut0 (.clk(clk), .reset(rst_n), .mv(b));

    typedef struct {
        string        name;
        logic [255:0] board;
        logic [3:0]   mask;
        logic [5:0]   frm;
        logic [5:0]   tsq;
        logic [3:0]   exp_mask;
        logic [3:0]   exp_mask0;
        logic         exp_move;
        logic         exp_ill;
        logic [5:0]   exp_rf;
        logic [5:0]   exp_rt;
    } vec_t;

    vec_t vecs[11];

`ifdef CASTLE_PATH_CHECK_EN
    localparam logic PATH_ILL = 1'b1;
`else
    localparam logic PATH_ILL = 1'b0;
`endif

    function automatic logic [255:0] put(input logic [255:0] bd, input int sq, input logic [3:0] pc);
        logic [255:0] r;
        r = bd;
        r[sq*4 +: 4] = pc;
        return r;
    endfunction

    function automatic logic [255:0] start_board();
        logic [255:0] bd;
        int back_w[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
        bd = '0;
        for (int c = 0; c < 8; c++) begin
            bd = put(bd, c, 4'(back_w[c]));
            bd = put(bd, 8 + c, 4'd1);
            bd = put(bd, 48 + c, 4'd9);
            bd = put(bd, 56 + c, 4'(back_w[c] + 8));
        end
        return bd;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Offers a move, checks the 3-edge latency, leaves the result held in HOLD.
    task automatic issue(input string nm, input logic [255:0] bd, input logic [3:0] m,
                         input logic [5:0] f, input logic [5:0] t);
        int n;
        n = 0;
        while (!a.move_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "/ready"}, 32'(a.move_ready), 32'd1);
        @(negedge clk);
        a.board = bd; a.castle_mask_in = m; a.from_sq = f; a.to_sq = t;
        a.move_valid = 1'b1;
        @(posedge clk);
        #1 a.move_valid = 1'b0;
        n = 0;
        while (!a.out_valid && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        chk({nm, "/latency"}, 32'(n), 32'd3);
    endtask

    task automatic release_out();
        @(negedge clk);
        a.out_ready = 1'b1;
        @(negedge clk);
        a.out_ready = 1'b0;
    endtask

    logic [255:0] sb;
    logic [3:0]   held_mask;
    logic [5:0]   held_rf;

    initial begin
        a.move_valid = 1'b0; a.out_ready = 1'b0;
        a.board = '0; a.castle_mask_in = '0; a.from_sq = '0; a.to_sq = '0;
        sb = start_board();

        vecs[0]  = '{"w_short",   put(put(sb, 5, 0), 6, 0),           4'b1111, 4,  6,  4'b1100, 4'b1100, 1, 0,        7,  5};
        vecs[1]  = '{"rook_h8",   sb,                                 4'b1111, 63, 55, 4'b1011, 4'b1011, 0, 0,        0,  0};
        vecs[2]  = '{"cap_a8",    put(sb, 40, 4'd5),                  4'b1111, 40, 56, 4'b0111, 4'b1111, 0, 0,        0,  0};
        vecs[3]  = '{"b_long_nb", put(put(put(sb, 57, 0), 58, 0), 59, 0), 4'b0111, 60, 58, 4'b0011, 4'b0011, 1, 1,   56, 59};
        vecs[4]  = '{"w_long_kb", put(put(sb, 2, 0), 3, 0),           4'b1111, 4,  2,  4'b1100, 4'b1100, 1, PATH_ILL, 0,  3};
        vecs[5]  = '{"no_rook",   put(put(put(sb, 5, 0), 6, 0), 7, 0), 4'b1111, 4,  6, 4'b1100, 4'b1100, 1, 1,        7,  5};
        vecs[6]  = '{"queen_e1",  put(sb, 4, 4'd5),                   4'b1111, 4,  12, 4'b1111, 4'b1111, 0, 0,        0,  0};
        vecs[7]  = '{"knight_a1", put(sb, 0, 4'd2),                   4'b1111, 0,  17, 4'b1101, 4'b1101, 0, 0,        0,  0};
        vecs[8]  = '{"zero_mask", put(put(sb, 5, 0), 6, 0),           4'b0000, 4,  6,  4'b0000, 4'b0000, 1, 1,        7,  5};
        vecs[9]  = '{"b_short",   put(put(sb, 61, 0), 62, 0),         4'b1111, 60, 62, 4'b0011, 4'b0011, 1, 0,        63, 61};
        vecs[10] = '{"cap_h1",    put(sb, 23, 4'd12),                 4'b1111, 23, 7,  4'b1110, 4'b1111, 0, 0,        0,  0};

        // Reset state while asserted and after release.
        #12;
        chk("rst/move_ready", 32'(a.move_ready), 32'd0);
        chk("rst/out_valid",  32'(a.out_valid),  32'd0);
        chk("rst/mask",       32'(a.castle_mask), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst/ready_after", 32'(a.move_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].name, vecs[i].board, vecs[i].mask, vecs[i].frm, vecs[i].tsq);
            chk({vecs[i].name, "/mask"},    32'(a.castle_mask),      32'(vecs[i].exp_mask));
            chk({vecs[i].name, "/mask0"},   32'(b.castle_mask),      32'(vecs[i].exp_mask0));
            chk({vecs[i].name, "/orig"},    32'(a.castle_mask_orig), 32'(vecs[i].mask));
            chk({vecs[i].name, "/move"},    32'(a.castle_move),      32'(vecs[i].exp_move));
            chk({vecs[i].name, "/illegal"}, 32'(a.castle_illegal),   32'(vecs[i].exp_ill));
            chk({vecs[i].name, "/rfrom"},   32'(a.rook_from),        32'(vecs[i].exp_rf));
            chk({vecs[i].name, "/rto"},     32'(a.rook_to),          32'(vecs[i].exp_rt));
            release_out();
            chk({vecs[i].name, "/valid_drop"}, 32'(a.out_valid), 32'd0);
        end

        // Stall in HOLD for 5 cycles while a second move is offered.
        issue("stall", vecs[1].board, 4'b1111, 63, 55);
        held_mask = a.castle_mask;
        held_rf   = a.rook_from;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a.move_valid = (k == 2); a.from_sq = 6'd7; a.to_sq = 6'd15;
            chk("stall/ready", 32'(a.move_ready), 32'd0);
            chk("stall/valid", 32'(a.out_valid),  32'd1);
        end
        a.move_valid = 1'b0;
        chk("stall/mask_stable", 32'(a.castle_mask), 32'(held_mask));
        chk("stall/mask_val",    32'(a.castle_mask), 32'b1011);
        chk("stall/rf_stable",   32'(a.rook_from),   32'(held_rf));
        release_out();
        for (int k = 0; k < 6; k++) @(negedge clk);
        chk("stall/no_second", 32'(a.out_valid), 32'd0);

        // out_ready while idle does nothing.
        @(negedge clk);
        a.out_ready = 1'b1;
        @(negedge clk);
        a.out_ready = 1'b0;
        chk("idle_ready/valid", 32'(a.out_valid),  32'd0);
        chk("idle_ready/ready", 32'(a.move_ready), 32'd1);

        // Reset asserted in the middle of HOLD.
        issue("rst_hold", vecs[0].board, 4'b1111, 4, 6);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_hold/valid", 32'(a.out_valid),   32'd0);
        chk("rst_hold/mask",  32'(a.castle_mask), 32'd0);
        chk("rst_hold/move",  32'(a.castle_move), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold/ready",  32'(a.move_ready), 32'd1);
        chk("rst_hold/valid2", 32'(a.out_valid),  32'd0);
        chk("rst_hold/rfrom",  32'(a.rook_from),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
